fetch_sequencer: RTL and testbench

//  Program-counter sequencer and fetch controller for the combinational instruction memory.

---
 rtl/fetch_sequencer_pkg.sv | 13 +
 rtl/fetch_skid_buf.sv | 28 ++
 rtl/fetch_sequencer.sv | 93 +++++++++
 tb/tb_fetch_sequencer.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared memory sizing, reset PC, fetch FSM states and PC legality helper
package fetch_sequencer_pkg;
  localparam int unsigned INST_MEM_SIZE = 1024;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef enum logic [1:0] {
    FS_RUN    = 2'd0,
    FS_HALTED = 2'd1,
    FS_FAULT  = 2'd2
  } fs_state_e;
  function automatic logic legal_pc(input logic [31:0] a, input int unsigned words);
    return a[1:0] == 2'b00 && a < (words << 2);
  endfunction
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: 2-entry FIFO of {pc, instr}; head stays put when empty so id_* hold their last values
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [63:0] din,
  output logic [63:0] dout,
  output logic [1:0]  count
);
  logic [63:0] e0, e1;
  logic [1:0] left;
  assign left = count - {1'b0, pop};
  assign dout = e0;
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      e0 <= '0;
      e1 <= '0;
    end else begin
      count <= flush ? 2'd0 : left + {1'b0, push};
      if (!flush && pop && count == 2'd2) e0 <= e1;
      if (!flush && push && left == 2'd0) e0 <= din;
      if (!flush && push && left == 2'd1) e1 <= din;
    end
  end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC sequencer and fetch controller feeding decode through a 2-entry skid buffer
// Optional bounds checking with FAULT state: define FETCH_BOUNDS_CHECK_EN.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned IMEM_WORDS = INST_MEM_SIZE
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
);
  fs_state_e state, state_n;
  logic [31:0] pc, pc_n, tgt;
  logic [63:0] head;
  logic [1:0] count;
  logic push, pop, bad, tgt_ok, loaded;
  assign imem_addr = pc;
  assign id_valid = count != 2'd0;
  assign pop = id_valid && id_ready;
  assign {id_pc, id_instr} = head;
  assign id_pc_plus4 = loaded ? id_pc + 32'd4 : 32'd0;
`ifdef FETCH_BOUNDS_CHECK_EN
  assign tgt = redirect_target;
  assign bad = !legal_pc(pc, IMEM_WORDS);
  assign tgt_ok = legal_pc(tgt, IMEM_WORDS);
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_fault <= 1'b0;
      fault_pc <= 32'd0;
    end else if (redirect_valid) begin
      if (tgt_ok) fetch_fault <= 1'b0;
    end else if (state == FS_RUN && bad) begin
      fetch_fault <= 1'b1;
      fault_pc <= pc;
    end
  end
`else
  assign tgt = redirect_target & ~32'h3;
  assign bad = 1'b0;
  assign tgt_ok = 1'b1;
  assign fetch_fault = 1'b0;
  assign fault_pc = 32'd0;
`endif
  // Priority: redirect, then fault detection, then normal fetch/halt.
  always_comb begin
    state_n = state;
    pc_n = pc;
    push = 1'b0;
    if (redirect_valid) begin
      pc_n = tgt;
      state_n = (state == FS_FAULT && !tgt_ok) ? FS_FAULT : halt ? FS_HALTED : FS_RUN;
    end else if (state == FS_RUN && bad) begin
      state_n = FS_FAULT;
    end else if (state != FS_FAULT) begin
      push = state == FS_RUN && !halt && (count != 2'd2 || pop);
      pc_n = push ? pc + 32'd4 : pc;
      state_n = halt ? FS_HALTED : FS_RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FS_RUN;
      pc <= RESET_PC;
      loaded <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      loaded <= loaded | push;
    end
  end
  fetch_skid_buf u_buf (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .flush(redirect_valid),
    .din({pc, imem_instr}),
    .dout(head),
    .count(count)
  );
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench with a queue-level reference model of the fetch stream
module tb_fetch_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] imem_addr, imem_instr, id_instr, id_pc, id_pc_plus4, redirect_target, fault_pc;
  logic id_valid, id_ready = 1'b0, redirect_valid = 1'b0, halt = 1'b0, fetch_fault;
  typedef struct {logic [31:0] pc, instr;} word_t;
  typedef struct {bit v; logic [31:0] pc, instr, addr; bit f; logic [31:0] fpc;} exp_t;
  word_t q[$];
  exp_t exp_q[$];
  logic [31:0] mpc = 32'd0, mfpc = 32'd0;
  bit mfault = 1'b0;
  int st = 0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;
  assign imem_instr = 32'h1000_0000 + {22'd0, imem_addr[11:2]};

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .id_pc_plus4(id_pc_plus4), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .halt(halt), .fetch_fault(fetch_fault),
    .fault_pc(fault_pc)
  );

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endfunction

  function automatic bit legal(logic [31:0] a);
`ifdef FETCH_BOUNDS_CHECK_EN
    return a[1:0] == 2'b00 && a < 32'd4096;
`else
    return 1'b1;
`endif
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("id_valid", {31'd0, id_valid}, {31'd0, e.v});
      if (e.v) begin
        chk("id_pc", id_pc, e.pc);
        chk("id_instr", id_instr, e.instr);
        chk("id_pc_plus4", id_pc_plus4, e.pc + 32'd4);
      end
      chk("imem_addr", imem_addr, e.addr);
      chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, e.f});
      chk("fault_pc", fault_pc, e.fpc);
    end
  end

  // One clock cycle: record what the DUT should show now, drive inputs, advance the model.
  task automatic step(input bit r, input bit rdy, input bit rv, input logic [31:0] tg, input bit h);
    exp_t e;
    e.v = q.size() > 0;
    e.pc = e.v ? q[0].pc : 32'd0;
    e.instr = e.v ? q[0].instr : 32'd0;
    e.addr = mpc;
    e.f = mfault;
    e.fpc = mfpc;
    exp_q.push_back(e);
    rst = r; id_ready = rdy; redirect_valid = rv; redirect_target = tg; halt = h;
    if (r) begin
      q.delete(); mpc = 32'd0; st = 0; mfault = 1'b0; mfpc = 32'd0;
    end else begin
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (rv) begin
        logic [31:0] t;
        t = tg;
`ifndef FETCH_BOUNDS_CHECK_EN
        t[1:0] = 2'b00;
`endif
        q.delete();
        mpc = t;
        if (!(st == 2 && !legal(t))) st = h ? 1 : 0;
        if (legal(t)) mfault = 1'b0;
      end else if (st == 0 && !legal(mpc)) begin
        st = 2; mfault = 1'b1; mfpc = mpc;
      end else if (st != 2) begin
        if (st == 0 && !h && q.size() < 2) begin
          q.push_back('{mpc, 32'h1000_0000 + {22'd0, mpc[11:2]}});
          mpc = mpc + 32'd4;
        end
        st = h ? 1 : 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    redirect_target = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_pc", id_pc, 32'd0);
    chk("rst_instr", id_instr, 32'd0);
    chk("rst_plus4", id_pc_plus4, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    repeat (8) step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0, 0);
    chk("bp_pc_hold", imem_addr, 32'd8);
    repeat (6) step(0, 1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h0000_00A0, 0);
    repeat (4) step(0, 1, 0, 0, 0);
    repeat (4) step(0, 1, 0, 0, 1);
    chk("halt_pc_frozen", imem_addr, mpc);
    repeat (4) step(0, 1, 0, 0, 0);
`ifdef FETCH_BOUNDS_CHECK_EN
    step(0, 1, 1, 32'h0000_0102, 0);
    repeat (4) step(0, 1, 0, 0, 0);
    chk("fault_set", {31'd0, fetch_fault}, 32'd1);
    chk("fault_pc_102", fault_pc, 32'h102);
    step(0, 1, 1, 32'h0000_0010, 0);
    repeat (4) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 32'h0000_0FF8, 0);
    repeat (6) step(0, 1, 0, 0, 0);
    chk("runoff_pc", fault_pc, 32'h1000);
    step(0, 1, 1, 32'h0000_0000, 0);
`endif
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tg;
      tg = ($urandom_range(0, 7) == 0) ? $urandom() : {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
      if (i % 400 < 20 && $urandom_range(0, 1) == 1) tg = {20'd0, 10'($urandom_range(1018, 1023)), 2'b00};
      step($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
           tg, $urandom_range(0, 9) == 0);
    end
    repeat (4) step(0, 1, 0, 0, 0);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
